// File: rtl/tug_key_conditioner.sv
// tug_key_conditioner
// Turns the two raw, bouncing, active-low player pushbuttons into clean
// one-cycle press pulses (L, R) and debounced "held" levels (L_held, R_held).
// Each channel has a 2-FF synchronizer, a debounce FSM and a pulse register.
// A held key never auto-repeats, and releases never produce a pulse.
//
// Ports
//   clk     in   system clock, all state on posedge
//   Reset   in   asynchronous active-low reset
//   KEY_L   in   raw left button, active-low, asynchronous to clk
//   KEY_R   in   raw right button, active-low, asynchronous to clk
//   L       out  registered 1-cycle pulse per accepted left press
//   R       out  registered 1-cycle pulse per accepted right press
//   L_held  out  debounced left level (1 = pressed)
//   R_held  out  debounced right level (1 = pressed)
//
// Optional feature macro: TUG_TIE_CANCEL_EN
//   When defined, L and R pulses that would fire on the same edge are both
//   suppressed; FSMs and held levels are unaffected.

module tug_key_conditioner #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic clk,
    input  logic Reset,
    input  logic KEY_L,
    input  logic KEY_R,
    output logic L,
    output logic R,
    output logic L_held,
    output logic R_held
);

    localparam int unsigned NUM_CH = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } state_t;

    // Bit 0 = left channel, bit 1 = right channel.
    logic [NUM_CH-1:0] s1_q;
    logic [NUM_CH-1:0] s2_q;
    logic [NUM_CH-1:0] fire_c;
    logic [NUM_CH-1:0] held_next_c;
    logic [NUM_CH-1:0] pulse_d;
    logic [NUM_CH-1:0] pulse_q;
    logic [NUM_CH-1:0] held_q;

    // Two-flop synchronizer; keys are inverted so 1 means pressed.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= ~{KEY_R, KEY_L};
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce FSM.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             fire;

        always_ff @(posedge clk or negedge Reset) begin
            if (!Reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            fire    = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q[ch]) begin
                        state_d = PRESS_CNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                PRESS_CNT: begin
                    if (!s2_q[ch]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!s2_q[ch]) begin
                        state_d = REL_CNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                REL_CNT: begin
                    if (s2_q[ch]) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign fire_c[ch]      = fire;
        assign held_next_c[ch] = (state_d == HELD) || (state_d == REL_CNT);
    end

    // Pulse combine; optional cancellation of simultaneous presses.
    always_comb begin
        pulse_d = fire_c;
`ifdef TUG_TIE_CANCEL_EN
        if (&fire_c) begin
            pulse_d = '0;
        end
`endif
    end

    // Output registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pulse_q <= '0;
            held_q  <= '0;
        end else begin
            pulse_q <= pulse_d;
            held_q  <= held_next_c;
        end
    end

    assign L      = pulse_q[0];
    assign R      = pulse_q[1];
    assign L_held = held_q[0];
    assign R_held = held_q[1];

endmodule

// File: tb/tb_tug_key_conditioner.sv
// tb_tug_key_conditioner
// Table-driven vectors, hand-written corner sequences and randomized key
// activity checked against a run-length debounce model.

module tb_tug_key_conditioner;

    localparam int DB = 4;

    logic clk;
    logic Reset;
    logic KEY_L;
    logic KEY_R;
    logic L;
    logic R;
    logic L_held;
    logic R_held;

    int vectors;
    int miscompares;

    tug_key_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk    (clk),
        .Reset  (Reset),
        .KEY_L  (KEY_L),
        .KEY_R  (KEY_R),
        .L      (L),
        .R      (R),
        .L_held (L_held),
        .R_held (R_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sync pipeline as a 2-deep delay, debounce as
    // "DB consecutive samples disagreeing with the level flip the level".
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl [2];
    int m_run [2];
    bit m_pulse [2];

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_pulse[c] = 0;
        end
    endfunction

    function automatic void model_edge(input bit rst, input bit kl, input bit kr);
        bit fire [2];
        bit key [2];
        if (!rst) begin
            model_clear();
            return;
        end
        key[0] = kl;
        key[1] = kr;
        for (int c = 0; c < 2; c++) begin
            fire[c] = 0;
            if (m_s2[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DB) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                    fire[c]  = m_lvl[c];
                end
            end else begin
                m_run[c] = 0;
            end
        end
`ifdef TUG_TIE_CANCEL_EN
        if (fire[0] && fire[1]) begin
            fire[0] = 0;
            fire[1] = 0;
        end
`endif
        for (int c = 0; c < 2; c++) begin
            m_pulse[c] = fire[c];
            m_s2[c]    = m_s1[c];
            m_s1[c]    = ~key[c];
        end
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: {L,R,L_held,R_held} got %b expected %b", name, $time, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    // Drive inputs between edges; an asserted reset clears the model at once.
    task automatic drive(input logic rst, input logic kl, input logic kr);
        Reset = rst;
        KEY_L = kl;
        KEY_R = kr;
        if (!rst) model_clear();
    endtask

    // One clock edge, model update, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge(Reset, KEY_L, KEY_R);
        #1;
    endtask

    task automatic tick_cmp(input string name);
        tick();
        check(name, {L, R, L_held, R_held}, {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1]});
    endtask

    typedef struct {
        logic       rst;
        logic       kl;
        logic       kr;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic kl, input logic kr, input logic [3:0] exp);
        vec_t v;
        v.rst = rst; v.kl = kl; v.kr = kr; v.exp = exp;
        tbl.push_back(v);
    endfunction

    int pulses;
    int first_at;
    int fall_at;
    bit held_dropped;
    bit kl_r;
    bit kr_r;

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_clear();
        drive(1'b0, 1'b1, 1'b1);
        #2;
        check("reset_state", {L, R, L_held, R_held}, 4'b0000);

        // Key held through reset: pulse after edge 5 (6th tick), held after.
        add(0, 0, 1, 4'b0000);
        for (int i = 0; i < 5; i++) add(1, 0, 1, 4'b0000);
        add(1, 0, 1, 4'b1010);
        add(1, 0, 1, 4'b0010);
        add(1, 0, 1, 4'b0010);
        // Bounce 0,1,0,1 then released: nothing accepted.
        add(0, 1, 1, 4'b0000);
        add(1, 0, 1, 4'b0000);
        add(1, 1, 1, 4'b0000);
        add(1, 0, 1, 4'b0000);
        for (int i = 0; i < 7; i++) add(1, 1, 1, 4'b0000);
        // Simultaneous presses.
        add(0, 1, 1, 4'b0000);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 4'b0000);
`ifdef TUG_TIE_CANCEL_EN
        add(1, 0, 0, 4'b0011);
`else
        add(1, 0, 0, 4'b1111);
`endif
        add(1, 0, 0, 4'b0011);
        add(1, 0, 0, 4'b0011);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].kl, tbl[i].kr);
            tick();
            check($sformatf("table[%0d]", i), {L, R, L_held, R_held}, tbl[i].exp);
        end

        // Right key held 50 cycles: one pulse on tick 6, held falls 6 ticks after release.
        drive(1'b0, 1'b1, 1'b1);
        tick_cmp("t3_reset");
        drive(1'b1, 1'b1, 1'b0);
        pulses = 0; first_at = 0;
        for (int i = 1; i <= 50; i++) begin
            tick_cmp("t3_hold");
            if (R) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        check_int("t3_pulse_count", pulses, 1);
        check_int("t3_pulse_tick", first_at, 6);
        drive(1'b1, 1'b1, 1'b1);
        fall_at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick_cmp("t3_release");
            if (R) pulses++;
            if (!R_held && fall_at == 0) fall_at = i;
        end
        check_int("t3_held_fall_tick", fall_at, 6);
        check_int("t3_no_release_pulse", pulses, 1);

        // Short release while held: no second pulse, held stays up.
        drive(1'b0, 1'b1, 1'b1);
        tick_cmp("t4_reset");
        drive(1'b1, 1'b0, 1'b1);
        pulses = 0; held_dropped = 0;
        for (int i = 0; i < 10; i++) begin
            tick_cmp("t4_press");
            if (L) pulses++;
        end
        drive(1'b1, 1'b1, 1'b1);
        tick_cmp("t4_gap");
        drive(1'b1, 1'b0, 1'b1);
        tick_cmp("t4_gap");
        for (int i = 0; i < 12; i++) begin
            tick_cmp("t4_repress");
            if (L) pulses++;
            if (!L_held) held_dropped = 1;
        end
        check_int("t4_pulse_count", pulses, 1);
        check_int("t4_held_dropped", int'(held_dropped), 0);

        // Reset at the pulse edge aborts; pulse follows after reset release.
        drive(1'b0, 1'b1, 1'b1);
        tick_cmp("t6_reset");
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick_cmp("t6_pre");
        drive(1'b0, 1'b0, 1'b1);
        tick_cmp("t6_abort");
        drive(1'b1, 1'b0, 1'b1);
        pulses = 0; first_at = 0;
        for (int i = 1; i <= 10; i++) begin
            tick_cmp("t6_after");
            if (L) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        check_int("t6_pulse_count", pulses, 1);
        check_int("t6_pulse_tick", first_at, 6);

        // Reset asserted while the pulse is high clears outputs without an edge.
        drive(1'b0, 1'b1, 1'b1);
        tick_cmp("t7_reset");
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick_cmp("t7_press");
        check("t7_pulse_up", {L, R, L_held, R_held}, 4'b1010);
        #2;
        drive(1'b0, 1'b0, 1'b1);
        #1;
        check("t7_async_clear", {L, R, L_held, R_held}, 4'b0000);
        drive(1'b1, 1'b1, 1'b1);

        // Randomized key activity with bounces and occasional resets.
        kl_r = 1; kr_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) kl_r = ~kl_r;
            if ($urandom_range(0, 5) == 0) kr_r = ~kr_r;
            if ($urandom_range(0, 11) == 0) begin
                kl_r = 0; kr_r = 0;
            end
            drive(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, kl_r, kr_r);
            tick_cmp("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
